// File: rtl/cobs_arb_pkg.sv
// Shared types and constants for the COBS stream arbiter.
package cobs_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    ABORT  = 2'd2,
    FLUSH  = 2'd3
  } arb_state_t;

  // Payload of the single beat emitted when a stalled packet is aborted.
  localparam logic [7:0] ABORT_MARKER_DATA = 8'h00;

  // Index width that stays at least 1 bit when there is only one source.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority picker: first asserted req at or after ptr,
// wrapping around N.
module rr_priority_picker
  import cobs_arb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Walk the requesters starting at ptr; the first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/cobs_stream_arbiter.sv
// Packet-level round-robin arbiter feeding one COBS encoder from NUM_SRC
// byte streams, with a mid-packet stall watchdog that aborts stuck packets.
module cobs_stream_arbiter
  import cobs_arb_pkg::*;
#(
  parameter  int NUM_SRC       = 2,
  parameter  int DATA_WIDTH    = 8,
  parameter  int STALL_TIMEOUT = 1024,
  localparam int IW            = idx_w(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]            s_tvalid,
  input  logic [NUM_SRC-1:0]            s_tlast,
  output logic [NUM_SRC-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic                          m_tvalid,
  output logic                          m_tlast,
  output logic                          m_tuser,
  input  logic                          m_tready,
  output logic [IW-1:0]                 grant_idx,
  output logic                          busy,
  output logic [15:0]                   abort_count
);

  localparam int             SW         = $clog2(STALL_TIMEOUT + 1);
  localparam logic [SW-1:0]  STALL_LAST = SW'(STALL_TIMEOUT - 1);

  arb_state_t                           state;
  logic [IW-1:0]                        rr_ptr;
  logic [SW-1:0]                        stall_cnt;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]   src_data;
  logic                                 pick_found;
  logic [IW-1:0]                        pick_idx;
  logic                                 g_valid;
  logic                                 g_last;
  logic [IW-1:0]                        next_ptr;

  assign src_data = s_tdata;
  assign g_valid  = s_tvalid[grant_idx];
  assign g_last   = s_tlast[grant_idx];
  assign busy     = (state != IDLE);
  assign next_ptr = (grant_idx == IW'(NUM_SRC - 1)) ? '0 : grant_idx + IW'(1);

  rr_priority_picker #(.N(NUM_SRC)) u_pick (
    .req   (s_tvalid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Output mux decoded from the registered state. STREAM passes the granted
  // source straight through so there is no extra latency per beat; the
  // async reset of state quiets every output in the same cycle.
  always_comb begin
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tuser  = 1'b0;
    s_tready = '0;
    case (state)
      STREAM: begin
        m_tdata             = src_data[grant_idx];
        m_tvalid            = g_valid;
        m_tlast             = g_last;
        s_tready[grant_idx] = m_tready;
      end
      ABORT: begin
        m_tdata  = DATA_WIDTH'(ABORT_MARKER_DATA);
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        m_tuser  = 1'b1;
      end
      FLUSH: begin
        s_tready[grant_idx] = 1'b1;
      end
      default: ;
    endcase
  end

  // Arbitration FSM, stall watchdog and saturating abort counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_idx   <= '0;
      stall_cnt   <= '0;
      abort_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_idx <= pick_idx;
            stall_cnt <= '0;
            state     <= STREAM;
          end
        end
        STREAM: begin
          // Only a silent source counts as a stall; encoder backpressure does not.
          if (g_valid) begin
            stall_cnt <= '0;
            if (m_tready && g_last) begin
              rr_ptr <= next_ptr;
              state  <= IDLE;
            end
          end else if (stall_cnt == STALL_LAST) begin
            stall_cnt <= '0;
            state     <= ABORT;
          end else begin
            stall_cnt <= stall_cnt + SW'(1);
          end
        end
        ABORT: begin
          if (m_tready) begin
            if (abort_count != 16'hFFFF) abort_count <= abort_count + 16'd1;
            state <= FLUSH;
          end
        end
        FLUSH: begin
          // Drain the rest of the aborted packet so its tail never reaches the encoder.
          if (g_valid && g_last) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cobs_stream_arbiter.sv
// Directed bench for cobs_stream_arbiter with two sources and a short watchdog.
module tb_cobs_stream_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] s_tdata;
  logic [1:0]  s_tvalid;
  logic [1:0]  s_tlast;
  logic [1:0]  s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tuser;
  logic        m_tready;
  logic [0:0]  grant_idx;
  logic        busy;
  logic [15:0] abort_count;

  int checks = 0;
  int errors = 0;

  // Source queues: {last, data}; output log: {tuser, last, data} + cycle index.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [9:0] out_q[$];
  int         out_cyc[$];
  bit         rand_rdy;
  int         stab_viol;

  cobs_stream_arbiter #(.NUM_SRC(2), .DATA_WIDTH(8), .STALL_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tuser(m_tuser),
    .m_tready(m_tready), .grant_idx(grant_idx), .busy(busy), .abort_count(abort_count)
  );

  always #5 clk = ~clk;

  // Ends #1 after a rising edge with reset released.
  task automatic pulse_reset;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1;
    reset_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // AXIS source/sink driver: replays q0/q1, logs accepted output beats.
  task automatic drive_run(input int max_cyc);
    logic       pv, f0, f1, fm;
    logic [9:0] pm;
    pv = 1'b0; pm = '0; stab_viol = 0;
    out_q.delete(); out_cyc.delete();
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      s_tvalid[0]   = (q0.size() > 0);
      s_tdata[7:0]  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
      s_tlast[0]    = (q0.size() > 0) ? q0[0][8] : 1'b0;
      s_tvalid[1]   = (q1.size() > 0);
      s_tdata[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
      s_tlast[1]    = (q1.size() > 0) ? q1[0][8] : 1'b0;
      m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (pv && (!m_tvalid || {m_tuser, m_tlast, m_tdata} != pm)) stab_viol++;
      pv = m_tvalid && !m_tready;
      pm = {m_tuser, m_tlast, m_tdata};
      f0 = s_tvalid[0] & s_tready[0];
      f1 = s_tvalid[1] & s_tready[1];
      fm = m_tvalid & m_tready;
      if (fm) begin
        out_q.push_back({m_tuser, m_tlast, m_tdata});
        out_cyc.push_back(cyc);
      end
      @(posedge clk); #1;
      if (f0) void'(q0.pop_front());
      if (f1) void'(q1.pop_front());
      if (q0.size() == 0 && q1.size() == 0) break;
    end
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1;
  endtask

  task automatic test_reset;
    s_tvalid = 2'b11; s_tlast = '0; s_tdata = 16'h5A5A; m_tready = 1'b1;
    reset_n = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tuser !== 1'b0) begin errors++;
      $display("FAIL reset_m got v%b l%b u%b want 000", m_tvalid, m_tlast, m_tuser); end
    checks++; if (s_tready !== 2'b00) begin errors++; $display("FAIL reset_s_tready got %b want 00", s_tready); end
    checks++; if (grant_idx !== 1'b0) begin errors++; $display("FAIL reset_grant got %0d want 0", grant_idx); end
    checks++; if (abort_count !== 16'd0) begin errors++; $display("FAIL reset_abort_count got %0d want 0", abort_count); end
    s_tvalid = '0; s_tdata = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_single_packet;
    q0 = '{9'h001, 9'h002, 9'h103};
    rand_rdy = 1'b0;
    drive_run(50);
    checks++; if (out_q.size() !== 3) begin errors++; $display("FAIL single_count got %0d want 3", out_q.size()); end
    if (out_q.size() == 3) begin
      checks++; if (out_q[0] !== 10'h001 || out_q[1] !== 10'h002 || out_q[2] !== 10'h103) begin errors++;
        $display("FAIL single_beats got %h %h %h want 001 002 103", out_q[0], out_q[1], out_q[2]); end
      checks++; if (out_cyc[0] !== 1) begin errors++; $display("FAIL single_latency got %0d want 1", out_cyc[0]); end
    end
    checks++; if (grant_idx !== 1'b0) begin errors++; $display("FAIL single_grant got %0d want 0", grant_idx); end
  endtask

  task automatic test_back_to_back;
    logic [9:0] exp_b[8];
    int         exp_c[8];
    pulse_reset();
    q0 = '{9'h010, 9'h111, 9'h012, 9'h113};
    q1 = '{9'h020, 9'h121, 9'h022, 9'h123};
    exp_b = '{10'h010, 10'h111, 10'h020, 10'h121, 10'h012, 10'h113, 10'h022, 10'h123};
    exp_c = '{1, 2, 4, 5, 7, 8, 10, 11};
    rand_rdy = 1'b0;
    drive_run(100);
    checks++; if (out_q.size() !== 8) begin errors++; $display("FAIL rr_count got %0d want 8", out_q.size()); end
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      checks++; if (out_q[i] !== exp_b[i]) begin errors++;
        $display("FAIL rr_beat[%0d] got %h want %h", i, out_q[i], exp_b[i]); end
      checks++; if (out_cyc[i] !== exp_c[i]) begin errors++;
        $display("FAIL rr_cycle[%0d] got %0d want %0d", i, out_cyc[i], exp_c[i]); end
    end
  endtask

  task automatic test_ready_toggle;
    q1 = '{9'h0AA, 9'h0BB, 9'h1CC};
    rand_rdy = 1'b1;
    drive_run(300);
    rand_rdy = 1'b0;
    checks++; if (out_q.size() !== 3) begin errors++; $display("FAIL toggle_count got %0d want 3", out_q.size()); end
    if (out_q.size() == 3) begin
      checks++; if (out_q[0] !== 10'h0AA || out_q[1] !== 10'h0BB || out_q[2] !== 10'h1CC) begin errors++;
        $display("FAIL toggle_beats got %h %h %h want 0aa 0bb 1cc", out_q[0], out_q[1], out_q[2]); end
    end
    checks++; if (stab_viol !== 0) begin errors++; $display("FAIL toggle_stable got %0d violations want 0", stab_viol); end
  endtask

  task automatic test_stall_abort;
    bit ok;
    pulse_reset();
    s_tvalid = 2'b11; s_tdata = {8'h55, 8'h11}; s_tlast = 2'b10; m_tready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== 8'h11 || grant_idx !== 1'b0) begin errors++;
      $display("FAIL stall_first got v%b d%h g%0d want v1 d11 g0", m_tvalid, m_tdata, grant_idx); end
    @(posedge clk); #1;
    s_tvalid[0] = 1'b0; m_tready = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      if (m_tvalid !== 1'b0 || m_tuser !== 1'b0 || busy !== 1'b1 || s_tready !== 2'b00) ok = 1'b0;
      @(posedge clk); #1;
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stall_window got early output want quiet for %0d cycles", TO); end
    @(negedge clk);
    checks++; if ({m_tvalid, m_tuser, m_tlast, m_tdata} !== 11'h700) begin errors++;
      $display("FAIL abort_marker got v%b u%b l%b d%h want v1 u1 l1 d00", m_tvalid, m_tuser, m_tlast, m_tdata); end
    checks++; if (s_tready !== 2'b00 || abort_count !== 16'd0) begin errors++;
      $display("FAIL abort_wait got rdy%b cnt%0d want rdy00 cnt0", s_tready, abort_count); end
    @(posedge clk); #1;
    m_tready = 1'b1;
    @(negedge clk);
    checks++; if ({m_tvalid, m_tuser, m_tlast, m_tdata} !== 11'h700) begin errors++;
      $display("FAIL abort_hold got v%b u%b l%b d%h want v1 u1 l1 d00", m_tvalid, m_tuser, m_tlast, m_tdata); end
    @(posedge clk); #1;
    s_tvalid[0] = 1'b1; s_tdata[7:0] = 8'h22; s_tlast[0] = 1'b0;
    @(negedge clk);
    checks++; if (abort_count !== 16'd1) begin errors++; $display("FAIL abort_count got %0d want 1", abort_count); end
    checks++; if (m_tvalid !== 1'b0 || s_tready !== 2'b01) begin errors++;
      $display("FAIL flush_a got v%b rdy%b want v0 rdy01", m_tvalid, s_tready); end
    @(posedge clk); #1;
    s_tdata[7:0] = 8'h33; s_tlast[0] = 1'b1;
    @(negedge clk);
    checks++; if (m_tvalid !== 1'b0 || s_tready !== 2'b01) begin errors++;
      $display("FAIL flush_b got v%b rdy%b want v0 rdy01", m_tvalid, s_tready); end
    @(posedge clk); #1;
    s_tvalid[0] = 1'b0; s_tlast[0] = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_done got busy%b want 0", busy); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (grant_idx !== 1'b1 || m_tvalid !== 1'b1 || m_tdata !== 8'h55 || m_tlast !== 1'b1 || m_tuser !== 1'b0) begin errors++;
      $display("FAIL after_abort got g%0d v%b d%h l%b u%b want g1 v1 d55 l1 u0", grant_idx, m_tvalid, m_tdata, m_tlast, m_tuser); end
    @(posedge clk); #1;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_packet;
    // Leave rr_ptr at 1 so the post-reset grant proves it was cleared.
    q0 = '{9'h1D1};
    rand_rdy = 1'b0;
    drive_run(20);
    s_tvalid = 2'b10; s_tdata = {8'hC1, 8'h00}; s_tlast = 2'b00; m_tready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (grant_idx !== 1'b1 || m_tvalid !== 1'b1) begin errors++;
      $display("FAIL midrst_pre got g%0d v%b want g1 v1", grant_idx, m_tvalid); end
    @(posedge clk); #1;
    s_tdata[15:8] = 8'hC2;
    reset_n = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0 || s_tready !== 2'b00 || busy !== 1'b0) begin errors++;
      $display("FAIL midrst_quiet got v%b rdy%b busy%b want v0 rdy00 busy0", m_tvalid, s_tready, busy); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    s_tvalid = 2'b11; s_tdata = {8'hC3, 8'hD0}; s_tlast = 2'b11;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (grant_idx !== 1'b0 || busy !== 1'b1 || m_tdata !== 8'hD0) begin errors++;
      $display("FAIL midrst_regrant got g%0d busy%b d%h want g0 busy1 dd0", grant_idx, busy, m_tdata); end
    @(posedge clk); #1;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0; s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1;
    rand_rdy = 1'b0; stab_viol = 0;
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_ready_toggle();
    test_stall_abort();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
